jpeg_izigzag_buf: RTL

//  Decoder-side inverse-zigzag reorder buffer. It is the read-back counterpart of the

---
 rtl/jpeg_izigzag_buf_if.sv | 27 ++
 rtl/jpeg_izigzag_buf.sv | 89 ++++++++
 2 files changed

// File: rtl/jpeg_izigzag_buf_if.sv
// Coefficient stream bundle between the entropy decoder, the reorder buffer and the IDCT.
// Latency: none, wires only.
// Backpressure: valid/ready on both the zigzag input side and the raster output side.
interface jpeg_izigzag_buf_if #(
    parameter int DATA_W = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_sob;
    logic              out_eob;

    // Producer/consumer side: feeds zigzag coefficients and sinks raster coefficients.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sob, out_eob
    );

    // Reorder buffer side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sob, out_eob
    );
endinterface

// File: rtl/jpeg_izigzag_buf.sv
// Inverse-zigzag ping-pong buffer: 64 zigzag coefficients in, same block out in raster order.
// Latency: out_valid rises 1 clk after the 64th input accept of a block.
// Backpressure: in_ready drops only when both banks hold undrained blocks (128 coefficients).
module jpeg_izigzag_buf #(
    parameter int DATA_W = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    jpeg_izigzag_buf_if.slave     bus
);
    // Zigzag position -> raster index.
    localparam logic [5:0] ZZ2R [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [5:0]        wcnt;
    logic [5:0]        rcnt;
    logic              wbank;
    logic              rbank;
    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic              wr_fire;
    logic              rd_fire;
    logic              wr_last;
    logic              rd_last;
    logic [DATA_W-1:0] mem [128];

    assign wr_fire = bus.in_valid && bus.in_ready;
    assign rd_fire = bus.out_valid && bus.out_ready;
    assign wr_last = wr_fire && (wcnt == 6'd63);
    assign rd_last = rd_fire && (rcnt == 6'd63);

    assign bus.in_ready  = !full[wbank];
    assign bus.out_valid = full[rbank];
    assign bus.out_data  = mem[{rbank, rcnt}];
    // Markers are gated by the bank flag so an idle buffer never shows a stray sob.
    assign bus.out_sob   = full[rbank] && (rcnt == 6'd0);
    assign bus.out_eob   = full[rbank] && (rcnt == 6'd63);

    // Bank flags: writer fills one bank while reader frees the other; both may land together.
    always_comb begin
        full_nxt = full;
        if (wr_last) begin
            full_nxt[wbank] = 1'b1;
        end
        if (rd_last) begin
            full_nxt[rbank] = 1'b0;
        end
    end

    // Write/read pointers and bank selection; counters wrap naturally at 63 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt  <= 6'd0;
            rcnt  <= 6'd0;
            wbank <= 1'b0;
            rbank <= 1'b0;
            full  <= 2'b00;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                wcnt <= wcnt + 6'd1;
            end
            if (wr_last) begin
                wbank <= !wbank;
            end
            if (rd_fire) begin
                rcnt <= rcnt + 6'd1;
            end
            if (rd_last) begin
                rbank <= !rbank;
            end
        end
    end

    // Coefficient storage, scattered to raster position on write; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[{wbank, ZZ2R[wcnt]}] <= bus.in_data;
        end
    end
endmodule
